// File: rtl/assoc_lru_buffer.sv
// Fully associative key/data store with true-LRU replacement, eviction reporting
// and a timed walk that emits every valid entry in ascending index order.
module assoc_lru_buffer #(
   parameter int KEY_WIDTH      = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_DATA_LOG2  = 3,
   parameter int DUMP_PERIOD    = 50_000_000,
   parameter int DUMP_CNT_WIDTH = 28
) (
   input  logic                     clk,
   input  logic                     async_reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [KEY_WIDTH-1:0]     req_key,
   input  logic [DATA_WIDTH-1:0]    req_data,
   output logic                     resp_valid,
   output logic                     resp_hit,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic                     evict_valid,
   output logic [KEY_WIDTH-1:0]     evict_key,
   output logic [DATA_WIDTH-1:0]    evict_data,
   input  logic                     dump_start,
   output logic                     dump_busy,
   output logic                     dump_valid,
   output logic [KEY_WIDTH-1:0]     dump_key,
   output logic [DATA_WIDTH-1:0]    dump_data,
   output logic [NUM_DATA_LOG2:0]   occupancy
);
   localparam int N = 2 ** NUM_DATA_LOG2;
   typedef logic [NUM_DATA_LOG2-1:0] idx_t;
   typedef logic [NUM_DATA_LOG2:0]   occ_t;
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DUMP = 1'b1} state_t;

   localparam idx_t AGE_MRU = idx_t'(N - 1);
   localparam idx_t AGE_ONE = idx_t'(1);
   localparam occ_t OCC_ONE = occ_t'(1);
   localparam logic [DUMP_CNT_WIDTH-1:0] TMR_LAST = DUMP_CNT_WIDTH'(DUMP_PERIOD - 1);
   localparam logic [DUMP_CNT_WIDTH-1:0] TMR_ONE  = DUMP_CNT_WIDTH'(1);
   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;
   localparam logic [1:0] OP_NONE   = 2'b11;

   state_t                    state_r, state_nxt_s;
   logic [N-1:0]              valid_r, valid_nxt_s;
   logic [KEY_WIDTH-1:0]      key_r [N];
   logic [KEY_WIDTH-1:0]      key_nxt_s [N];
   logic [DATA_WIDTH-1:0]     data_r [N];
   logic [DATA_WIDTH-1:0]     data_nxt_s [N];
   idx_t                      age_r [N];
   idx_t                      age_nxt_s [N];
   occ_t                      occ_r, occ_nxt_s;
   logic [DUMP_CNT_WIDTH-1:0] tmr_r, tmr_nxt_s;
   idx_t                      dump_idx_r, dump_emit_idx_s;
   logic                      dump_emit_s;

   logic                      accept_s;
   logic [1:0]                op_s;
   logic                      hit_s, free_s, next_s;
   idx_t                      hit_idx_s, free_idx_s, lru_idx_s, first_idx_s, next_idx_s;
   idx_t                      victim_s, tgt_s, tgt_age_s;
   logic                      promote_s, demote_s;
   logic                      resp_hit_nxt_s, evict_valid_nxt_s;
   logic [DATA_WIDTH-1:0]     resp_data_nxt_s, evict_data_nxt_s;
   logic [KEY_WIDTH-1:0]      evict_key_nxt_s;

   logic                      resp_valid_r, resp_hit_r, evict_valid_r, dump_valid_r;
   logic [DATA_WIDTH-1:0]     resp_data_r, evict_data_r, dump_data_r;
   logic [KEY_WIDTH-1:0]      evict_key_r, dump_key_r;

   assign accept_s = req_valid && (state_r == ST_IDLE);
   assign op_s     = accept_s ? req_op : OP_NONE;
   assign victim_s = free_s ? free_idx_s : lru_idx_s;

   // Priority searches; descending scan leaves the lowest matching index last.
   always_comb begin
      hit_s = 1'b0;  hit_idx_s = '0;  free_s = 1'b0;  free_idx_s = '0;
      lru_idx_s = '0;  first_idx_s = '0;  next_s = 1'b0;  next_idx_s = '0;
      for (int i = N - 1; i >= 0; i--) begin
         hit_s       = hit_s | (valid_r[i] && (key_r[i] == req_key));
         hit_idx_s   = (valid_r[i] && (key_r[i] == req_key)) ? idx_t'(i) : hit_idx_s;
         free_s      = free_s | !valid_r[i];
         free_idx_s  = !valid_r[i] ? idx_t'(i) : free_idx_s;
         lru_idx_s   = (age_r[i] == '0) ? idx_t'(i) : lru_idx_s;
         first_idx_s = valid_r[i] ? idx_t'(i) : first_idx_s;
         next_s      = next_s | (valid_r[i] && (idx_t'(i) > dump_idx_r));
         next_idx_s  = (valid_r[i] && (idx_t'(i) > dump_idx_r)) ? idx_t'(i) : next_idx_s;
      end
   end

   // Request execution: next contents, ages, occupancy and response values.
   always_comb begin
      valid_nxt_s = valid_r;  key_nxt_s = key_r;  data_nxt_s = data_r;
      occ_nxt_s = occ_r;  promote_s = 1'b0;  demote_s = 1'b0;  tgt_s = hit_idx_s;
      resp_hit_nxt_s = 1'b0;  resp_data_nxt_s = '0;  evict_valid_nxt_s = 1'b0;
      evict_key_nxt_s = evict_key_r;  evict_data_nxt_s = evict_data_r;
      case (op_s)
         OP_LOOKUP: begin
            if (hit_s) begin
               resp_hit_nxt_s  = 1'b1;
               resp_data_nxt_s = data_r[hit_idx_s];
               promote_s       = 1'b1;
            end else begin
               resp_hit_nxt_s  = 1'b0;
            end
         end
         OP_WRITE: begin
            if (hit_s) begin
               data_nxt_s[hit_idx_s] = req_data;
               resp_hit_nxt_s        = 1'b1;
               promote_s             = 1'b1;
            end else begin
               tgt_s                 = victim_s;
               promote_s             = 1'b1;
               valid_nxt_s[victim_s] = 1'b1;
               key_nxt_s[victim_s]   = req_key;
               data_nxt_s[victim_s]  = req_data;
               if (valid_r[victim_s]) begin
                  evict_valid_nxt_s = 1'b1;
                  evict_key_nxt_s   = key_r[victim_s];
                  evict_data_nxt_s  = data_r[victim_s];
               end else begin
                  occ_nxt_s = occ_r + OCC_ONE;
               end
            end
         end
         OP_INVAL: begin
            if (hit_s) begin
               valid_nxt_s[hit_idx_s] = 1'b0;
               resp_hit_nxt_s         = 1'b1;
               demote_s               = 1'b1;
               occ_nxt_s              = occ_r - OCC_ONE;
            end else begin
               resp_hit_nxt_s = 1'b0;
            end
         end
         default: resp_hit_nxt_s = 1'b0;
      endcase
      tgt_age_s = age_r[tgt_s];
      for (int i = 0; i < N; i++) begin
         if (promote_s) begin
            if (idx_t'(i) == tgt_s)        age_nxt_s[i] = AGE_MRU;
            else if (age_r[i] > tgt_age_s) age_nxt_s[i] = age_r[i] - AGE_ONE;
            else                           age_nxt_s[i] = age_r[i];
         end else if (demote_s) begin
            if (idx_t'(i) == tgt_s)        age_nxt_s[i] = '0;
            else if (age_r[i] < tgt_age_s) age_nxt_s[i] = age_r[i] + AGE_ONE;
            else                           age_nxt_s[i] = age_r[i];
         end else begin
            age_nxt_s[i] = age_r[i];
         end
      end
   end

   // Dump FSM next state: first emission on entry, then one per elapsed period.
   always_comb begin
      state_nxt_s = state_r;  tmr_nxt_s = tmr_r;
      dump_emit_s = 1'b0;  dump_emit_idx_s = dump_idx_r;
      case (state_r)
         ST_IDLE: begin
            if (dump_start && !accept_s && (occ_r != '0)) begin
               state_nxt_s = ST_DUMP;  dump_emit_s = 1'b1;
               dump_emit_idx_s = first_idx_s;  tmr_nxt_s = '0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DUMP: begin
            if (tmr_r == TMR_LAST) begin
               tmr_nxt_s = '0;
               if (next_s) begin
                  dump_emit_s = 1'b1;  dump_emit_idx_s = next_idx_s;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               tmr_nxt_s = tmr_r + TMR_ONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state and dump timer.
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         state_r <= ST_IDLE;
         tmr_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         tmr_r   <= tmr_nxt_s;
      end
   end

   // Entry storage, LRU ages and valid count.
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         valid_r <= '0;
         occ_r   <= '0;
         for (int i = 0; i < N; i++) begin
            key_r[i]  <= '0;
            data_r[i] <= '0;
            age_r[i]  <= idx_t'(i);
         end
      end else begin
         valid_r <= valid_nxt_s;
         occ_r   <= occ_nxt_s;
         key_r   <= key_nxt_s;
         data_r  <= data_nxt_s;
         age_r   <= age_nxt_s;
      end
   end

   // Registered response, eviction and dump outputs.
   always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
         resp_valid_r <= 1'b0;  resp_hit_r <= 1'b0;  resp_data_r <= '0;
         evict_valid_r <= 1'b0;  evict_key_r <= '0;  evict_data_r <= '0;
         dump_valid_r <= 1'b0;  dump_key_r <= '0;  dump_data_r <= '0;  dump_idx_r <= '0;
      end else begin
         resp_valid_r  <= accept_s;
         resp_hit_r    <= resp_hit_nxt_s;
         resp_data_r   <= resp_data_nxt_s;
         evict_valid_r <= evict_valid_nxt_s;
         evict_key_r   <= evict_key_nxt_s;
         evict_data_r  <= evict_data_nxt_s;
         dump_valid_r  <= dump_emit_s;
         if (dump_emit_s) begin
            dump_key_r  <= key_r[dump_emit_idx_s];
            dump_data_r <= data_r[dump_emit_idx_s];
            dump_idx_r  <= dump_emit_idx_s;
         end
      end
   end

   assign req_ready   = (state_r == ST_IDLE);
   assign dump_busy   = (state_r == ST_DUMP);
   assign resp_valid  = resp_valid_r;
   assign resp_hit    = resp_hit_r;
   assign resp_data   = resp_data_r;
   assign evict_valid = evict_valid_r;
   assign evict_key   = evict_key_r;
   assign evict_data  = evict_data_r;
   assign dump_valid  = dump_valid_r;
   assign dump_key    = dump_key_r;
   assign dump_data   = dump_data_r;
   assign occupancy   = occ_r;
endmodule

// File: tb/tb_assoc_lru_buffer.sv
// Randomized bench for assoc_lru_buffer against an LRU-ordered-list reference model,
// with directed fill/evict, invalidate-refill, dump timing and mid-dump reset cases.
module tb_assoc_lru_buffer;
   localparam int N  = 8;
   localparam int DP = 4;

   logic       clk = 1'b0;
   logic       async_reset = 1'b0;
   logic       req_valid = 1'b0, req_ready;
   logic [1:0] req_op = 2'b00;
   logic [7:0] req_key = 8'h00, req_data = 8'h00;
   logic       resp_valid, resp_hit, evict_valid;
   logic [7:0] resp_data, evict_key, evict_data;
   logic       dump_start = 1'b0, dump_busy, dump_valid;
   logic [7:0] dump_key, dump_data;
   logic [3:0] occupancy;

   int total = 0;
   int bad   = 0;

   bit         m_valid [N];
   logic [7:0] m_key [N];
   logic [7:0] m_data [N];
   int         lru_q [$];

   assoc_lru_buffer #(.KEY_WIDTH(8), .DATA_WIDTH(8), .NUM_DATA_LOG2(3),
                      .DUMP_PERIOD(DP), .DUMP_CNT_WIDTH(4)) dut (
      .clk(clk), .async_reset(async_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_key(req_key), .req_data(req_data),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
      .evict_valid(evict_valid), .evict_key(evict_key), .evict_data(evict_data),
      .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
      .dump_key(dump_key), .dump_data(dump_data), .occupancy(occupancy));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int m_occ();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   // move entry e to the MRU end (to_mru) or the LRU end of the recency list
   task automatic m_touch(input int e, input bit to_mru);
      for (int i = 0; i < lru_q.size(); i++)
         if (lru_q[i] == e) begin lru_q.delete(i); break; end
      if (to_mru) lru_q.push_back(e);
      else        lru_q.push_front(e);
   endtask

   task automatic m_reset();
      lru_q = {};
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0; m_key[i] = 8'h00; m_data[i] = 8'h00;
         lru_q.push_back(i);
      end
   endtask

   task automatic m_apply(input logic [1:0] op, input logic [7:0] key, input logic [7:0] data,
                          output bit hit, output logic [7:0] rdata,
                          output bit ev, output logic [7:0] ek, output logic [7:0] ed);
      int e = -1;
      int v = -1;
      hit = 1'b0; rdata = 8'h00; ev = 1'b0; ek = 8'h00; ed = 8'h00;
      for (int i = 0; i < N; i++)
         if (e < 0 && m_valid[i] && m_key[i] == key) e = i;
      case (op)
         2'b00: if (e >= 0) begin hit = 1'b1; rdata = m_data[e]; m_touch(e, 1'b1); end
         2'b01: begin
            if (e >= 0) begin
               hit = 1'b1; m_data[e] = data; m_touch(e, 1'b1);
            end else begin
               for (int i = 0; i < N; i++) if (v < 0 && !m_valid[i]) v = i;
               if (v < 0) v = lru_q[0];
               if (m_valid[v]) begin ev = 1'b1; ek = m_key[v]; ed = m_data[v]; end
               m_valid[v] = 1'b1; m_key[v] = key; m_data[v] = data;
               m_touch(v, 1'b1);
            end
         end
         2'b10: if (e >= 0) begin hit = 1'b1; m_valid[e] = 1'b0; m_touch(e, 1'b0); end
         default: hit = 1'b0;
      endcase
   endtask

   task automatic do_req(input logic [1:0] op, input logic [7:0] key, input logic [7:0] data,
                         input string tag);
      bit hit, ev;
      logic [7:0] rd, ek, ed;
      m_apply(op, key, data, hit, rd, ev, ek, ed);
      req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
      check_val({tag, ".ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_val({tag, ".rvalid"}, 32'(resp_valid), 32'd1);
      check_val({tag, ".hit"},    32'(resp_hit),   32'(hit));
      check_val({tag, ".rdata"},  32'(resp_data),  32'(rd));
      check_val({tag, ".evict"},  32'(evict_valid), 32'(ev));
      if (ev) begin
         check_val({tag, ".ekey"},  32'(evict_key),  32'(ek));
         check_val({tag, ".edata"}, 32'(evict_data), 32'(ed));
      end
      check_val({tag, ".occ"}, 32'(occupancy), 32'(m_occ()));
   endtask

   task automatic apply_reset();
      req_valid = 1'b0; dump_start = 1'b0;
      @(negedge clk); async_reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); async_reset = 1'b1;
      m_reset();
   endtask

   // dump walk with a lookup held pending from the first pulse on
   task automatic run_dump(input string tag);
      int vlist [$];
      int end_off, j;
      bit hit, ev, pulse;
      logic [7:0] rd, ek, ed, rk;
      for (int i = 0; i < N; i++) if (m_valid[i]) vlist.push_back(i);
      end_off = 1 + DP * vlist.size();
      rk = m_key[vlist[vlist.size() - 1]];
      @(negedge clk); dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      req_valid = 1'b1; req_op = 2'b00; req_key = rk;
      m_apply(2'b00, rk, 8'h00, hit, rd, ev, ek, ed);
      for (int c = 1; c <= end_off + 1; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         j = (c - 1) / DP;
         pulse = ((c - 1) % DP == 0) && (j < vlist.size());
         if (j >= vlist.size()) j = vlist.size() - 1;
         check_val({tag, ".dvalid"}, 32'(dump_valid), 32'(pulse));
         check_val({tag, ".busy"},   32'(dump_busy),  32'(c < end_off));
         check_val({tag, ".ready"},  32'(req_ready),  32'(c >= end_off));
         check_val({tag, ".dkey"},   32'(dump_key),   32'(m_key[vlist[j]]));
         check_val({tag, ".ddata"},  32'(dump_data),  32'(m_data[vlist[j]]));
         check_val({tag, ".rvalid"}, 32'(resp_valid), 32'(c == end_off + 1));
         if (c == end_off) req_valid = 1'b1;
         if (c == end_off + 1) begin
            req_valid = 1'b0;
            check_val({tag, ".hit"},   32'(resp_hit),  32'(hit));
            check_val({tag, ".rdata"}, 32'(resp_data), 32'(rd));
         end
      end
   endtask

   initial begin
      bit hit, ev;
      logic [7:0] rd, ek, ed;
      m_reset();
      apply_reset();
      check_val("rst.occ",    32'(occupancy),   32'd0);
      check_val("rst.ready",  32'(req_ready),   32'd1);
      check_val("rst.busy",   32'(dump_busy),   32'd0);
      check_val("rst.rvalid", 32'(resp_valid),  32'd0);
      check_val("rst.evict",  32'(evict_valid), 32'd0);
      check_val("rst.dvalid", 32'(dump_valid),  32'd0);
      do_req(2'b00, 8'h05, 8'h00, "miss05");
      @(posedge clk); #1;
      check_val("rvalid.pulse", 32'(resp_valid), 32'd0);
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      check_val("dump.empty", 32'(dump_busy), 32'd0);

      for (int i = 0; i < N; i++) do_req(2'b01, 8'(8'h10 + i), 8'(8'hA0 + i), "fill");
      do_req(2'b00, 8'h10, 8'h00, "lk10");
      do_req(2'b01, 8'h20, 8'hB0, "wr20");
      check_val("wr20.ekey_dir", 32'(evict_key), 32'h11);
      do_req(2'b00, 8'h10, 8'h00, "lk10b");
      do_req(2'b01, 8'h30, 8'h01, "wr30a");
      do_req(2'b01, 8'h30, 8'h02, "wr30b");
      do_req(2'b00, 8'h30, 8'h00, "lk30");
      do_req(2'b11, 8'h30, 8'h00, "rsvd");

      apply_reset();
      for (int i = 0; i < N; i++) do_req(2'b01, 8'(8'h40 + i), 8'(8'hC0 + i), "fill2");
      do_req(2'b10, 8'h45, 8'h00, "inv45");
      do_req(2'b01, 8'h50, 8'hD0, "refill");
      do_req(2'b00, 8'h50, 8'h00, "lk50");
      do_req(2'b10, 8'h99, 8'h00, "invmiss");

      apply_reset();
      for (int i = 0; i < 400; i++)
         do_req(2'($urandom_range(0, 3)), 8'($urandom_range(16, 27)), 8'($urandom), "rnd");

      apply_reset();
      for (int i = 0; i < 7; i++) do_req(2'b01, 8'(8'h60 + i), 8'(8'hE0 + i), "fill3");
      do_req(2'b10, 8'h60, 8'h00, "inv");
      do_req(2'b10, 8'h62, 8'h00, "inv");
      do_req(2'b10, 8'h63, 8'h00, "inv");
      do_req(2'b10, 8'h65, 8'h00, "inv");
      run_dump("dump");

      @(negedge clk);
      m_apply(2'b00, 8'h64, 8'h00, hit, rd, ev, ek, ed);
      req_valid = 1'b1; req_op = 2'b00; req_key = 8'h64; dump_start = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; dump_start = 1'b0;
      check_val("simul.rvalid", 32'(resp_valid), 32'd1);
      check_val("simul.hit",    32'(resp_hit),   32'(hit));
      check_val("simul.rdata",  32'(resp_data),  32'(rd));
      check_val("simul.busy",   32'(dump_busy),  32'd0);
      check_val("simul.dvalid", 32'(dump_valid), 32'd0);

      @(negedge clk); dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      check_val("mid.busy0", 32'(dump_busy), 32'd1);
      @(posedge clk); #1;
      async_reset = 1'b0;
      #1;
      check_val("mid.busy",   32'(dump_busy),  32'd0);
      check_val("mid.occ",    32'(occupancy),  32'd0);
      check_val("mid.dvalid", 32'(dump_valid), 32'd0);
      check_val("mid.ready",  32'(req_ready),  32'd1);
      @(posedge clk);
      @(negedge clk); async_reset = 1'b1;
      m_reset();
      do_req(2'b00, 8'h64, 8'h00, "postrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
